// File: rtl/bullet_round_seq_if.sv
// Bus between the game FSM / shell loader and the bullet round sequencer.
// master = game side (drives start/next/rand), slave = sequencer.
interface bullet_round_seq_if #(
  parameter int ROUNDS = 4,
  parameter int LEVELS = 3,
  parameter int CNT_W  = 4,
  parameter int PLAY_W = 8
);
  localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int RAND_W = ROUNDS * LVL_W;
  localparam int RND_W  = $clog2(ROUNDS);

  logic              i_start;
  logic              i_next;
  logic [RAND_W-1:0] i_rand;
  logic              o_valid;
  logic [RND_W-1:0]  o_round;
  logic [CNT_W-1:0]  o_count;
  logic              o_wrap;
  logic [PLAY_W-1:0] o_played;

  modport master (output i_start, i_next, i_rand,
                  input  o_valid, o_round, o_count, o_wrap, o_played);
  modport slave  (input  i_start, i_next, i_rand,
                  output o_valid, o_round, o_count, o_wrap, o_played);
endinterface

// File: rtl/bullet_round_seq.sv
// Round sequencer: latches a per-round bullet-count table on start, steps rounds 0..ROUNDS-1 then loops 1..ROUNDS-1.
// Optional BULLET_RESHUFFLE_EN: reload the whole table from i_rand on every wrap.
module bullet_round_seq #(
  parameter int ROUNDS = 4,
  parameter int LEVELS = 3,
  parameter int BASE   = 4,
  parameter int STEP   = 2,
  parameter int CNT_W  = 4,
  parameter int PLAY_W = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  bullet_round_seq_if.slave bus
);
  localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int RND_W  = $clog2(ROUNDS);
  localparam int WIDE_W = CNT_W + LVL_W;

  if (ROUNDS < 2 || LEVELS < 1 || (BASE + STEP * (LEVELS - 1)) >= (2 ** CNT_W)) begin : g_bad_cfg
    $error("bullet_round_seq: illegal ROUNDS/LEVELS or top count does not fit CNT_W");
  end

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                         state_q, state_d;
  logic [ROUNDS-1:0][CNT_W-1:0]   tbl_q, tbl_d, load_tbl;
  logic [RND_W-1:0]               round_q, round_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           wrap_q, wrap_d;
  logic [PLAY_W-1:0]              played_q, played_d;
  logic                           is_last;
  logic                           load;

  // Candidate table from i_rand; round r may only reach levels 0..min(r,LEVELS-1).
  for (genvar r = 0; r < ROUNDS; r++) begin : g_entry
    localparam int CAP = (r < LEVELS - 1) ? r : LEVELS - 1;
    logic [LVL_W-1:0]  fld, lvl;
    logic [WIDE_W-1:0] wide;
    assign fld         = bus.i_rand[r*LVL_W +: LVL_W];
    assign lvl         = (fld > LVL_W'(CAP)) ? LVL_W'(CAP) : fld;
    assign wide        = WIDE_W'(BASE) + WIDE_W'(STEP) * WIDE_W'(lvl);
    assign load_tbl[r] = wide[CNT_W-1:0];
  end

  assign is_last = (round_q == RND_W'(ROUNDS - 1));

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    played_d = played_q;
    wrap_d   = 1'b0;
    load     = 1'b0;
    if (bus.i_start) begin
      load     = 1'b1;
      state_d  = ACTIVE;
      round_d  = '0;
      played_d = '0;
    end else if (bus.i_next && state_q == ACTIVE) begin
      round_d = is_last ? RND_W'(1) : round_q + RND_W'(1);
      wrap_d  = is_last;
      if (played_q != '1) played_d = played_q + PLAY_W'(1);
`ifdef BULLET_RESHUFFLE_EN
      load = is_last;
`endif
    end
    tbl_d   = load ? load_tbl : tbl_q;
    // Count follows the table that will be current after this edge.
    count_d = tbl_d[round_d];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      tbl_q    <= {ROUNDS{CNT_W'(BASE)}};
      round_q  <= '0;
      count_q  <= CNT_W'(BASE);
      wrap_q   <= 1'b0;
      played_q <= '0;
    end else begin
      state_q  <= state_d;
      tbl_q    <= tbl_d;
      round_q  <= round_d;
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      played_q <= played_d;
    end
  end

  assign bus.o_valid  = (state_q == ACTIVE);
  assign bus.o_round  = round_q;
  assign bus.o_count  = count_q;
  assign bus.o_wrap   = wrap_q;
  assign bus.o_played = played_q;
endmodule

// File: tb/tb_bullet_round_seq.sv
// Bench for bullet_round_seq: directed test-plan steps plus a randomized run against an integer model.
module tb_bullet_round_seq;
  logic i_clk = 1'b0;
  logic i_rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 i_clk = ~i_clk;

  bullet_round_seq_if #(.PLAY_W(8)) bus ();
  bullet_round_seq_if #(.PLAY_W(2)) bus2 ();

  bullet_round_seq #(.PLAY_W(8)) u_dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus.slave));
  bullet_round_seq #(.PLAY_W(2)) u_sat (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus2.slave));

  // Integer model of the sequencer
  int m_tbl[4];
  bit m_active;
  int m_round;
  int m_played;
  bit m_wrap;

  function automatic int entry(input logic [7:0] rnd, input int r);
    int f, cap, lvl;
    f   = (rnd >> (2 * r)) & 3;
    cap = (r < 2) ? r : 2;
    lvl = (f < cap) ? f : cap;
    return 4 + 2 * lvl;
  endfunction

  task automatic model_load(input logic [7:0] rnd);
    for (int r = 0; r < 4; r++) m_tbl[r] = entry(rnd, r);
  endtask

  task automatic model_edge(input bit rst_n, input bit start, input bit nxt, input logic [7:0] rnd);
    m_wrap = 1'b0;
    if (!rst_n) begin
      m_active = 0; m_round = 0; m_played = 0;
      for (int r = 0; r < 4; r++) m_tbl[r] = 4;
    end else if (start) begin
      model_load(rnd);
      m_active = 1; m_round = 0; m_played = 0;
    end else if (nxt && m_active) begin
      m_played++;
      if (m_round == 3) begin
        m_round = 1;
        m_wrap  = 1'b1;
`ifdef BULLET_RESHUFFLE_EN
        model_load(rnd);
`endif
      end else begin
        m_round++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("valid",    32'(bus.o_valid),   32'(m_active));
    chk("round",    32'(bus.o_round),   32'(m_round));
    chk("count",    32'(bus.o_count),   32'(m_tbl[m_round]));
    chk("wrap",     32'(bus.o_wrap),    32'(m_wrap));
    chk("played8",  32'(bus.o_played),  32'((m_played > 255) ? 255 : m_played));
    chk("played2",  32'(bus2.o_played), 32'((m_played > 3) ? 3 : m_played));
    chk("count2",   32'(bus2.o_count),  32'(m_tbl[m_round]));
  endtask

  task automatic step(input bit rst_n, input bit start, input bit nxt, input logic [7:0] rnd);
    i_rst_n      = rst_n;
    bus.i_start  = start; bus.i_next  = nxt; bus.i_rand  = rnd;
    bus2.i_start = start; bus2.i_next = nxt; bus2.i_rand = rnd;
    @(posedge i_clk);
    model_edge(rst_n, start, nxt, rnd);
    #1;
    check_model();
  endtask

  initial begin
    int exp_cnt[8];
    int exp_rnd[8];
    int exp_ply[5];
    int wrap_cnt;
    exp_cnt = '{4, 6, 8, 8, 6, 8, 8, 6};
    exp_rnd = '{0, 1, 2, 3, 1, 2, 3, 1};
    exp_ply = '{1, 2, 3, 3, 3};

    // Reset (with start/next asserted: reset wins), then idle with i_next pulses
    step(0, 1, 1, 8'hFF);
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_count", 32'(bus.o_count), 4);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 8'hFF);
      chk("idle_valid", 32'(bus.o_valid), 0);
      chk("idle_round", 32'(bus.o_round), 0);
      chk("idle_count", 32'(bus.o_count), 4);
      chk("idle_played", 32'(bus.o_played), 0);
    end

    // Start with 11_10_01_00 then 7 round ends
    step(1, 1, 0, 8'b11_10_01_00);
    chk("seq_count0", 32'(bus.o_count), 32'(exp_cnt[0]));
    chk("seq_valid",  32'(bus.o_valid), 1);
    for (int i = 1; i < 8; i++) begin
      step(1, 0, 1, 8'h5A);
      chk("seq_count", 32'(bus.o_count), 32'(exp_cnt[i]));
      chk("seq_round", 32'(bus.o_round), 32'(exp_rnd[i]));
      chk("seq_wrap",  32'(bus.o_wrap),  32'((i == 4 || i == 7) ? 1 : 0));
    end

    // Level caps: FF -> 4,6,8,8 ; 00 -> 4,4,4,4
    step(1, 1, 0, 8'hFF);
    chk("capFF_0", 32'(bus.o_count), 4);
    for (int i = 1; i < 4; i++) begin
      step(1, 0, 1, 8'h00);
      chk("capFF", 32'(bus.o_count), 32'((i == 1) ? 6 : 8));
    end
    step(1, 1, 0, 8'h00);
    chk("cap00_0", 32'(bus.o_count), 4);
    for (int i = 1; i < 4; i++) begin
      step(1, 0, 1, 8'hFF);
      chk("cap00", 32'(bus.o_count), 4);
    end

    // Start and next together at round 2: start wins
    step(1, 1, 0, 8'b11_10_01_00);
    step(1, 0, 1, 8'h00);
    step(1, 0, 1, 8'h00);
    chk("pre_round", 32'(bus.o_round), 2);
    step(1, 1, 1, 8'hFF);
    chk("both_round",  32'(bus.o_round),  0);
    chk("both_count",  32'(bus.o_count),  4);
    chk("both_played", 32'(bus.o_played), 0);

    // Wrap with a different i_rand at the wrap edge
    step(1, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 8'h00);
    step(1, 0, 1, 8'hFF);
`ifdef BULLET_RESHUFFLE_EN
    wrap_cnt = 6;
`else
    wrap_cnt = 4;
`endif
    chk("wrap_count", 32'(bus.o_count), 32'(wrap_cnt));
    chk("wrap_pulse", 32'(bus.o_wrap), 1);
    step(1, 0, 1, 8'h00);
    chk("wrap_count_r2", 32'(bus.o_count), 32'((wrap_cnt == 6) ? 8 : 4));
    step(1, 0, 1, 8'h00);
    chk("wrap_count_r3", 32'(bus.o_count), 32'((wrap_cnt == 6) ? 8 : 4));

    // Saturation on the 2-bit counter, then reset mid-match
    step(1, 1, 0, 8'hE4);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 8'h00);
      chk("sat_played", 32'(bus2.o_played), 32'(exp_ply[i]));
    end
    step(0, 0, 1, 8'hFF);
    chk("mid_rst_valid",  32'(bus.o_valid),  0);
    chk("mid_rst_round",  32'(bus.o_round),  0);
    chk("mid_rst_count",  32'(bus.o_count),  4);
    chk("mid_rst_wrap",   32'(bus.o_wrap),   0);
    chk("mid_rst_played", 32'(bus.o_played), 0);

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 2) != 0), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
